mem_arbiter: RTL and testbench

Sequencer and arbiter placed in front of the unified single-port instruction/data memory. It shares the memory between the instruction-fetch requester and the load/store requester using a req/ack handshake. It issues registered memory commands, waits out the memory read latency, and returns read data with a one-cycle ack pulse. Data accesses have priority, bounded by a starvation guard that guarantees fetch progress.

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the memory.
// The slave view belongs to the arbiter; the master view drives requests and memory data.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for a single-port unified memory shared by instruction fetch and
// load/store. Data has priority; a starvation counter forces a fetch grant after
// STARVE_MAX consecutive data wins over a pending fetch.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [2:0] WaitInit  = 3'(MEM_LAT - 1);
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              gnt_data_q, gnt_data_d;  // 1: data requester owns the access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        starve_q, starve_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  // Next-state: arbitration in idle, latency countdown, read data capture.
  always_comb begin
    state_d    = state_q;
    gnt_data_d = gnt_data_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      StIdle: begin
        if (bus.if_req || bus.d_req) begin
          state_d = StIssue;
          if (bus.d_req && (!bus.if_req || (starve_q < StarveMax))) begin
            gnt_data_d = 1'b1;
            we_d       = bus.d_we;
            addr_d     = bus.d_addr;
            wdata_d    = bus.d_wdata;
            // Only a win over a waiting fetch counts towards starvation.
            if (bus.if_req) starve_d = starve_q + 4'd1;
          end else begin
            gnt_data_d = 1'b0;
            we_d       = 1'b0;
            addr_d     = bus.if_addr;
            starve_d   = 4'd0;
          end
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StResp;
        end else begin
          state_d = StWait;
          cnt_d   = WaitInit;
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          state_d = StResp;
          if (gnt_data_q) d_rdata_d  = bus.mem_rdata;
          else            if_rdata_d = bus.mem_rdata;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously so an aborted access vanishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_data_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= 3'd0;
      starve_q   <= 4'd0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_data_q <= gnt_data_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Outputs decode directly from registered state, so they are glitch-free.
  always_comb begin
    bus.mem_en    = (state_q == StIssue);
    bus.mem_we    = (state_q == StIssue) && we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.if_ack    = (state_q == StResp) && !gnt_data_q;
    bus.d_ack     = (state_q == StResp) && gnt_data_q;
    bus.if_rdata  = if_rdata_q;
    bus.d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run checked against a transaction-level memory/fairness model.
module tb_mem_arbiter;

  localparam int unsigned StarveMax = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(StarveMax)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(StarveMax)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3)
  );

  function automatic logic [31:0] init_word(input logic [7:0] a);
    if (a == 8'h10) return 32'h8C22_0004;
    return 32'h5A5A_0000 ^ (32'(a) * 32'h0001_0203);
  endfunction

  // Memory models: read data appears MEM_LAT cycles after the mem_en cycle, random otherwise.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  logic [31:0] ref1 [256];

  always @(posedge clk) begin
    if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[7:0]] <= b1.mem_wdata;
    pipe1 <= (b1.mem_en && !b1.mem_we) ? mem1[b1.mem_addr[7:0]] : $urandom;
  end
  assign b1.mem_rdata = pipe1;

  always @(posedge clk) begin
    if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr[7:0]] <= b3.mem_wdata;
    pipe3[0] <= (b3.mem_en && !b3.mem_we) ? mem3[b3.mem_addr[7:0]] : $urandom;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign b3.mem_rdata = pipe3[2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_if = '0;
  logic [31:0] exp_d  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  // One isolated access on the MEM_LAT=1 instance, checked cycle by cycle.
  task automatic run_vec(input vec_t v);
    int n;
    bit acked;
    @(posedge clk); #1;
    if (v.fetch) begin
      b1.if_req = 1'b1; b1.if_addr = v.addr;
    end else begin
      b1.d_req = 1'b1; b1.d_we = v.we; b1.d_addr = v.addr; b1.d_wdata = v.wdata;
    end
    n = 0; acked = 1'b0;
    while (!acked && n < 20) begin
      @(posedge clk); #1; n++;
      check("vec_mem_en", 32'(b1.mem_en), 32'(n == 1));
      if (n == 1) begin
        check("vec_mem_addr", b1.mem_addr, v.addr);
        check("vec_mem_we", 32'(b1.mem_we), 32'(v.we));
        if (v.we) check("vec_mem_wdata", b1.mem_wdata, v.wdata);
      end else begin
        check("vec_mem_we_idle", 32'(b1.mem_we), 32'd0);
      end
      acked = v.fetch ? b1.if_ack : b1.d_ack;
      check("vec_other_ack", 32'(v.fetch ? b1.d_ack : b1.if_ack), 32'd0);
    end
    b1.if_req = 1'b0; b1.d_req = 1'b0;
    check("vec_latency", 32'(n), 32'(v.exp_lat));
    if (v.fetch) exp_if = v.exp_rdata;
    else if (!v.we) exp_d = v.exp_rdata;
    else ref1[v.addr[7:0]] = v.wdata;
    check("vec_if_rdata", b1.if_rdata, exp_if);
    check("vec_d_rdata", b1.d_rdata, exp_d);
    @(posedge clk); #1;
    check("vec_ack_pulse", 32'({b1.if_ack, b1.d_ack}), 32'd0);
    check("vec_if_rdata_hold", b1.if_rdata, exp_if);
  endtask

  // Both requesters high together; keep=1 re-issues data reads back to back.
  task automatic both_high(input bit keep, input int exp_dwins, input int exp_if_lat);
    int n, dwins;
    bit if_done;
    logic [31:0] daddr;
    @(posedge clk); #1;
    daddr = 32'h40;
    b1.if_req = 1'b1; b1.if_addr = 32'h10;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = daddr;
    n = 0; dwins = 0; if_done = 1'b0;
    while (!if_done && n < 60) begin
      @(posedge clk); #1; n++;
      if (b1.d_ack) begin
        dwins++;
        check("both_d_rdata", b1.d_rdata, ref1[daddr[7:0]]);
        exp_d = ref1[daddr[7:0]];
        if (keep) begin
          daddr = daddr + 32'd1; b1.d_addr = daddr;
        end else begin
          b1.d_req = 1'b0;
        end
      end
      if (b1.if_ack) begin
        if_done = 1'b1;
        check("both_if_rdata", b1.if_rdata, ref1[8'h10]);
        exp_if = ref1[8'h10];
        b1.if_req = 1'b0; b1.d_req = 1'b0;
      end
    end
    check("both_if_acked", 32'(if_done), 32'd1);
    check("both_data_wins", 32'(dwins), 32'(exp_dwins));
    check("both_if_latency", 32'(n), 32'(exp_if_lat));
    repeat (6) begin
      @(posedge clk); #1;
      check("both_no_extra_ack", 32'({b1.if_ack, b1.d_ack}), 32'd0);
    end
  endtask

  // Randomized-run state.
  bit          if_pend, d_pend, issuing;
  int          if_gap, d_gap, if_wait, d_wait, dwins_r;
  logic [31:0] if_a, d_a;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] <= init_word(8'(i));
      mem3[i] <= init_word(8'(i));
      ref1[i] = init_word(8'(i));
    end
    b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0;
    b1.d_addr = '0; b1.d_wdata = '0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0;
    b3.d_addr = '0; b3.d_wdata = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_if_ack", 32'(b1.if_ack), 32'd0);
    check("rst_d_ack", 32'(b1.d_ack), 32'd0);
    check("rst_mem_en", 32'(b1.mem_en), 32'd0);
    check("rst_mem_we", 32'(b1.mem_we), 32'd0);
    check("rst_mem_addr", b1.mem_addr, 32'd0);
    check("rst_mem_wdata", b1.mem_wdata, 32'd0);
    check("rst_if_rdata", b1.if_rdata, 32'd0);
    check("rst_d_rdata", b1.d_rdata, 32'd0);
    rst_n = 1'b1;

    // Directed vector table (MEM_LAT=1): reads ack after 3 cycles, writes after 2.
    vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'h8C22_0004,     3};
    vecs[1] = '{1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h0,             2};
    vecs[2] = '{1'b0, 1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF,     3};
    vecs[3] = '{1'b1, 1'b0, 32'h21, 32'h0,         init_word(8'h21),  3};
    vecs[4] = '{1'b0, 1'b1, 32'h22, 32'h1234_5678, 32'h0,             2};
    vecs[5] = '{1'b1, 1'b0, 32'h22, 32'h0,         32'h1234_5678,     3};
    vecs[6] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'h8C22_0004,     3};
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Simultaneous: data first (ack 3), fetch in the following idle (ack 7).
    both_high(1'b0, 1, 7);
    // Starvation: 4 data reads of 4 cycles each, then fetch; twice to show the counter cleared.
    both_high(1'b1, StarveMax, StarveMax * 4 + 3);
    both_high(1'b1, StarveMax, StarveMax * 4 + 3);

    // MEM_LAT=3 instance: read and fetch ack at T+5 with data from the right cycle.
    for (int k = 0; k < 2; k++) begin
      int n;
      bit acked;
      @(posedge clk); #1;
      if (k == 0) begin
        b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 32'h33;
      end else begin
        b3.if_req = 1'b1; b3.if_addr = 32'h10;
      end
      n = 0; acked = 1'b0;
      while (!acked && n < 20) begin
        @(posedge clk); #1; n++;
        acked = (k == 0) ? b3.d_ack : b3.if_ack;
      end
      b3.d_req = 1'b0; b3.if_req = 1'b0;
      check("lat3_latency", 32'(n), 32'd5);
      if (k == 0) check("lat3_d_rdata", b3.d_rdata, init_word(8'h33));
      else        check("lat3_if_rdata", b3.if_rdata, 32'h8C22_0004);
    end

    // Reset pulsed during WAIT of a read: everything clears at once, no ack ever appears.
    @(posedge clk); #1;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h20;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_outputs", 32'({b1.if_ack, b1.d_ack, b1.mem_en, b1.mem_we}), 32'd0);
    check("arst_mem_addr", b1.mem_addr, 32'd0);
    check("arst_if_rdata", b1.if_rdata, 32'd0);
    check("arst_d_rdata", b1.d_rdata, 32'd0);
    b1.d_req = 1'b0;
    exp_if = '0; exp_d = '0;
    repeat (3) begin
      @(posedge clk); #1;
      check("arst_no_ack", 32'(b1.d_ack), 32'd0);
    end
    rst_n = 1'b1;
    b1.d_req = 1'b1; b1.d_addr = 32'h22;
    begin
      int n;
      n = 0;
      while (!b1.d_ack && n < 20) begin
        @(posedge clk); #1; n++;
      end
      b1.d_req = 1'b0;
      check("arst_next_latency", 32'(n), 32'd3);
      check("arst_next_rdata", b1.d_rdata, 32'h1234_5678);
      exp_d = 32'h1234_5678;
    end
    @(posedge clk); #1;

    // Randomized concurrent traffic against the reference memory and fairness bounds.
    if_pend = 0; d_pend = 0; if_gap = 0; d_gap = 0; if_wait = 0; d_wait = 0; dwins_r = 0;
    issuing = 1;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 600) issuing = 0;
      if (b1.if_ack && b1.d_ack) check("rand_dual_ack", 32'd1, 32'd0);
      if (b1.if_ack) begin
        check("rand_if_ack_pending", 32'(if_pend), 32'd1);
        exp_if = ref1[if_a[7:0]];
        check("rand_if_starve", 32'(dwins_r <= StarveMax + 1), 32'd1);
        check("rand_if_wait", 32'(if_wait <= 6 * 4 + 4), 32'd1);
        if_pend = 0; b1.if_req = 1'b0; dwins_r = 0; if_gap = $urandom_range(0, 2);
      end
      if (b1.d_ack) begin
        check("rand_d_ack_pending", 32'(d_pend), 32'd1);
        if (b1.d_we) ref1[d_a[7:0]] = b1.d_wdata;
        else exp_d = ref1[d_a[7:0]];
        check("rand_d_wait", 32'(d_wait <= 14), 32'd1);
        if (if_pend) dwins_r++;
        d_pend = 0; b1.d_req = 1'b0; d_gap = $urandom_range(0, 3);
      end
      check("rand_if_rdata", b1.if_rdata, exp_if);
      check("rand_d_rdata", b1.d_rdata, exp_d);
      if (if_pend) if_wait++;
      if (d_pend) d_wait++;
      if (!if_pend && issuing) begin
        if (if_gap == 0) begin
          if_a = 32'($urandom_range(0, 15));
          b1.if_addr = if_a; b1.if_req = 1'b1; if_pend = 1; if_wait = 0;
        end else begin
          if_gap--;
        end
      end
      if (!d_pend && issuing) begin
        if (d_gap == 0) begin
          d_a = 32'($urandom_range(0, 15));
          b1.d_addr = d_a; b1.d_we = 1'($urandom_range(0, 1));
          b1.d_wdata = $urandom; b1.d_req = 1'b1; d_pend = 1; d_wait = 0;
        end else begin
          d_gap--;
        end
      end
    end
    check("rand_drained", 32'({if_pend, d_pend}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule
